// File: rtl/sp_dram_arbiter.sv
// sp_dram_arbiter: round-robin front end for two requesters sharing
// a single-port DRAM user interface, one outstanding read at a time.
module sp_dram_arbiter #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    input  logic [MASK_WIDTH-1:0] a_mask,
    input  logic                  a_we,
    input  logic                  a_re,
    output logic                  a_ack,
    output logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    input  logic [MASK_WIDTH-1:0] b_mask,
    input  logic                  b_we,
    input  logic                  b_re,
    output logic                  b_ack,
    output logic                  b_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [MASK_WIDTH-1:0] mem_mask,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WGAP,
        RWAIT0,
        RWAIT
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;

    // r_last / r_owner: 1 means requester B
    logic                  r_last;
    logic                  r_owner;
    logic                  r_is_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [MASK_WIDTH-1:0] r_mask;

    logic                  r_mem_we;
    logic                  r_mem_re;
    logic                  r_a_ack;
    logic                  r_b_ack;
    logic                  r_a_valid;
    logic                  r_b_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_a_pend;
    logic                  w_b_pend;
    logic                  w_pick_b;
    logic                  w_grant_rd;
    logic                  w_load;
    logic                  w_capture;
    logic                  w_mem_we_nx;
    logic                  w_mem_re_nx;
    logic                  w_a_ack_nx;
    logic                  w_b_ack_nx;
    logic                  w_a_valid_nx;
    logic                  w_b_valid_nx;

    assign w_a_pend   = a_we | a_re;
    assign w_b_pend   = b_we | b_re;
    // B wins alone, or on a tie when A was served last
    assign w_pick_b   = w_b_pend & (~w_a_pend | ~r_last);
    // a request with both strobes set is treated as a read
    assign w_grant_rd = w_pick_b ? b_re : a_re;

    // next state plus next value of every registered strobe
    always_comb begin
        w_state_nx   = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_mem_we_nx  = 1'b0;
        w_mem_re_nx  = 1'b0;
        w_a_ack_nx   = 1'b0;
        w_b_ack_nx   = 1'b0;
        w_a_valid_nx = 1'b0;
        w_b_valid_nx = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (mem_ready && (w_a_pend || w_b_pend)) begin
                    w_load      = 1'b1;
                    w_mem_we_nx = ~w_grant_rd;
                    w_mem_re_nx = w_grant_rd;
                    w_a_ack_nx  = ~w_pick_b;
                    w_b_ack_nx  = w_pick_b;
                    w_state_nx  = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nx = r_is_rd ? RWAIT0 : WGAP;
            end
            WGAP: begin
                w_state_nx = IDLE;
            end
            RWAIT0: begin
                w_state_nx = RWAIT;
            end
            RWAIT: begin
                if (mem_ready) begin
                    w_capture    = 1'b1;
                    w_a_valid_nx = ~r_owner;
                    w_b_valid_nx = r_owner;
                    w_state_nx   = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // state, grant history, strobes and returned read line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_owner   <= 1'b0;
            r_is_rd   <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_re  <= 1'b0;
            r_a_ack   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_mem_we  <= w_mem_we_nx;
            r_mem_re  <= w_mem_re_nx;
            r_a_ack   <= w_a_ack_nx;
            r_b_ack   <= w_b_ack_nx;
            r_a_valid <= w_a_valid_nx;
            r_b_valid <= w_b_valid_nx;
            if (w_load) begin
                r_last  <= w_pick_b;
                r_owner <= w_pick_b;
                r_is_rd <= w_grant_rd;
            end
            if (w_capture) begin
                r_rd_data <= mem_dout;
            end
        end
    end

    // command payload of the granted requester, held through issue
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_addr <= w_pick_b ? b_addr : a_addr;
            r_din  <= w_pick_b ? b_din  : a_din;
            r_mask <= w_pick_b ? b_mask : a_mask;
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_re   = r_mem_re;
    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign mem_mask = r_mask;
    assign a_ack    = r_a_ack;
    assign b_ack    = r_b_ack;
    assign a_valid  = r_a_valid;
    assign b_valid  = r_b_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_sp_dram_arbiter.sv
// tb_sp_dram_arbiter: directed scenarios plus a randomized run
// against a transaction-timing reference model of the arbiter.
module tb_sp_dram_arbiter;

    localparam int AW = 25;
    localparam int DW = 128;
    localparam int MW = 16;

    localparam logic [DW-1:0] LINE  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [DW-1:0] WDATA = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic [MW-1:0] a_mask, b_mask;
    logic          a_we, a_re, b_we, b_re;
    logic          a_ack, a_valid, b_ack, b_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [MW-1:0] mem_mask;
    logic          mem_we, mem_re, mem_ready;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] dram [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sp_dram_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MASK_WIDTH(MW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_mask   (a_mask),
        .a_we     (a_we),
        .a_re     (a_re),
        .a_ack    (a_ack),
        .a_valid  (a_valid),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_mask   (b_mask),
        .b_we     (b_we),
        .b_re     (b_re),
        .b_ack    (b_ack),
        .b_valid  (b_valid),
        .rd_data  (rd_data),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_mask (mem_mask),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_ready(mem_ready),
        .mem_dout (mem_dout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic idle_inputs();
        a_we = 1'b0; a_re = 1'b0; b_we = 1'b0; b_re = 1'b0;
        a_addr = '0; a_din = '0; a_mask = '0;
        b_addr = '0; b_din = '0; b_mask = '0;
        mem_ready = 1'b1;
        mem_dout  = '0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        d = rand_line();
        idle_inputs();
        rst = 1'b1;
        a_we = 1'b1; a_addr = 25'h0ABCDEF; a_din = d; a_mask = 16'h0F0F;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({mem_we, mem_re, a_ack, b_ack, a_valid, b_valid} !== 6'b0
                || rd_data !== '0) begin
                bad++;
                $display("FAIL reset_hold: strobes=%b rd_data=%h want 0",
                    {mem_we, mem_re, a_ack, b_ack, a_valid, b_valid}, rd_data);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if ({mem_we, mem_re, a_ack, b_ack} !== 4'b1010) begin
            bad++;
            $display("FAIL reset_release: we/re/aack/back=%b want 1010",
                {mem_we, mem_re, a_ack, b_ack});
        end
        total++;
        if (mem_addr !== 25'h0ABCDEF || mem_din !== d || mem_mask !== 16'h0F0F) begin
            bad++;
            $display("FAIL reset_payload: addr=%h mask=%h want 0abcdef 0f0f",
                mem_addr, mem_mask);
        end
        tick();
        a_we = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_write();
        int n_we, n_re, n_aack, n_other, first;
        idle_inputs();
        n_we = 0; n_re = 0; n_aack = 0; n_other = 0; first = -1;
        a_we = 1'b1; a_addr = 25'h0000123; a_din = WDATA; a_mask = 16'hFFFF;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (mem_we) begin
                n_we++;
                if (first < 0) first = i;
                total++;
                if (mem_addr !== 25'h0000123 || mem_din !== WDATA
                    || mem_mask !== 16'hFFFF) begin
                    bad++;
                    $display("FAIL write_payload: addr=%h din=%h mask=%h",
                        mem_addr, mem_din, mem_mask);
                end
            end
            if (mem_re) n_re++;
            if (a_ack) n_aack++;
            if (b_ack || b_valid || a_valid) n_other++;
            if (i == 2) a_we = 1'b0;
        end
        total++;
        if (first != 1) begin
            bad++;
            $display("FAIL write_latency: strobe at cycle %0d want 1", first);
        end
        total++;
        if (n_we != 1 || n_aack != 1) begin
            bad++;
            $display("FAIL write_pulses: mem_we=%0d a_ack=%0d want 1 1", n_we, n_aack);
        end
        total++;
        if (n_re != 0 || n_other != 0) begin
            bad++;
            $display("FAIL write_quiet: mem_re=%0d others=%0d want 0 0", n_re, n_other);
        end
    endtask

    task automatic test_contention();
        int ph_a, ph_b;
        int cyc_q[$];
        int side_q[$];
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        ph_a = 0; ph_b = 0;
        a_addr = AW'($urandom()); b_addr = AW'($urandom());
        a_we = 1'b1; b_we = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (a_ack) begin
                cyc_q.push_back(i); side_q.push_back(0);
                total++;
                if (mem_addr !== a_addr || b_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL cont_a_payload: addr=%h want %h", mem_addr, a_addr);
                end
            end
            if (b_ack) begin
                cyc_q.push_back(i); side_q.push_back(1);
                total++;
                if (mem_addr !== b_addr || a_ack !== 1'b0) begin
                    bad++;
                    $display("FAIL cont_b_payload: addr=%h want %h", mem_addr, b_addr);
                end
            end
            if (ph_a == 1) begin a_we = 1'b0; ph_a = 2; end
            else if (ph_a == 2) begin a_addr = AW'($urandom()); a_we = 1'b1; ph_a = 0; end
            else if (a_ack) ph_a = 1;
            if (ph_b == 1) begin b_we = 1'b0; ph_b = 2; end
            else if (ph_b == 2) begin b_addr = AW'($urandom()); b_we = 1'b1; ph_b = 0; end
            else if (b_ack) ph_b = 1;
        end
        idle_inputs();
        repeat (4) tick();
        total++;
        if (side_q.size() < 4) begin
            bad++;
            $display("FAIL cont_count: %0d issues want >=4", side_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (side_q[k] != k % 2 || cyc_q[k] != 1 + 3 * k) begin
                    bad++;
                    $display("FAIL cont_order: issue %0d side=%0d cyc=%0d want side=%0d cyc=%0d",
                        k, side_q[k], cyc_q[k], k % 2, 1 + 3 * k);
                end
            end
        end
    endtask

    task automatic test_read();
        int nb, ackc, nre, nwe, nv, vcyc, nother;
        idle_inputs();
        nb = 0; ackc = -1; nre = 0; nwe = 0; nv = 0; vcyc = -1; nother = 0;
        b_re = 1'b1; b_addr = 25'h1FFFFFF;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (b_ack) begin nb++; ackc = i; end
            if (mem_re) begin
                nre++;
                total++;
                if (mem_addr !== 25'h1FFFFFF) begin
                    bad++;
                    $display("FAIL read_addr: addr=%h want 1ffffff", mem_addr);
                end
            end
            if (mem_we) nwe++;
            if (a_valid || a_ack) nother++;
            if (b_valid) begin
                nv++; vcyc = i;
                total++;
                if (rd_data !== LINE) begin
                    bad++;
                    $display("FAIL read_data: rd_data=%h want %h", rd_data, LINE);
                end
            end
            if (i == 2) b_re = 1'b0;
            mem_ready = !(i >= 3 && i <= 8);
            mem_dout  = (i == 9) ? LINE : rand_line();
        end
        total++;
        if (nb != 1 || ackc != 1 || nre != 1 || nwe != 0) begin
            bad++;
            $display("FAIL read_issue: b_ack=%0d@%0d mem_re=%0d mem_we=%0d want 1@1 1 0",
                nb, ackc, nre, nwe);
        end
        total++;
        if (nv != 1 || vcyc != 10 || nother != 0) begin
            bad++;
            $display("FAIL read_valid: b_valid=%0d@%0d a_side=%0d want 1@10 0",
                nv, vcyc, nother);
        end
        total++;
        if (rd_data !== LINE) begin
            bad++;
            $display("FAIL read_hold: rd_data=%h want %h", rd_data, LINE);
        end
        idle_inputs();
    endtask

    task automatic test_blocking();
        int first_we, vcyc;
        logic [DW-1:0] line2;
        idle_inputs();
        line2 = rand_line();
        first_we = -1; vcyc = -1;
        b_re = 1'b1; b_addr = AW'($urandom());
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (mem_we && first_we < 0) begin
                first_we = i;
                total++;
                if (a_ack !== 1'b1 || mem_addr !== 25'h0055AA1) begin
                    bad++;
                    $display("FAIL block_issue: a_ack=%b addr=%h want 1 0055aa1",
                        a_ack, mem_addr);
                end
            end
            if (b_valid) vcyc = i;
            if (i == 2) b_re = 1'b0;
            if (i == 4) begin a_we = 1'b1; a_addr = 25'h0055AA1; a_mask = 16'h00FF; end
            if (i == 10) a_we = 1'b0;
            mem_ready = !(i >= 3 && i <= 6);
            mem_dout  = (i == 7) ? line2 : rand_line();
        end
        total++;
        if (vcyc != 8 || first_we != 9) begin
            bad++;
            $display("FAIL block_order: b_valid@%0d mem_we@%0d want 8 9", vcyc, first_we);
        end
        total++;
        if (rd_data !== line2) begin
            bad++;
            $display("FAIL block_data: rd_data=%h want %h", rd_data, line2);
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_read();
        int nbv;
        logic [DW-1:0] rl;
        idle_inputs();
        rl = rand_line();
        nbv = 0;
        b_re = 1'b1; b_addr = AW'($urandom());
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (b_valid) nbv++;
            if (i == 6) begin
                total++;
                if ({mem_we, mem_re, a_ack, b_ack, a_valid, b_valid} !== 6'b0
                    || rd_data !== '0) begin
                    bad++;
                    $display("FAIL midrst_outputs: strobes=%b rd_data=%h want 0",
                        {mem_we, mem_re, a_ack, b_ack, a_valid, b_valid}, rd_data);
                end
            end
            if (i == 9) begin
                total++;
                if (a_ack !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 25'h0000777) begin
                    bad++;
                    $display("FAIL midrst_next: a_ack=%b mem_re=%b addr=%h want 1 1 0000777",
                        a_ack, mem_re, mem_addr);
                end
            end
            if (i == 12) begin
                total++;
                if (a_valid !== 1'b1 || rd_data !== rl) begin
                    bad++;
                    $display("FAIL midrst_read: a_valid=%b rd_data=%h want 1 %h",
                        a_valid, rd_data, rl);
                end
            end
            if (i == 2) b_re = 1'b0;
            rst = (i == 5);
            mem_ready = (i <= 2) || (i >= 6);
            mem_dout  = (i == 11) ? rl : rand_line();
            if (i == 8) begin a_re = 1'b1; a_addr = 25'h0000777; end
            if (i == 10) a_re = 1'b0;
        end
        total++;
        if (nbv != 0) begin
            bad++;
            $display("FAIL midrst_no_valid: b_valid pulses=%0d want 0", nbv);
        end
        idle_inputs();
        repeat (2) tick();
    endtask

    task automatic test_random(input int ncyc);
        logic          on [2];
        int            ph [2];
        int            gap [2];
        logic [AW-1:0] ra [2];
        logic [DW-1:0] rd [2];
        logic [MW-1:0] rm [2];
        logic          rw [2];
        logic          rr [2];
        int            m_free, m_from, m_own, m_last, s, kind, d_lat;
        bit            m_rd;
        logic [AW-1:0] m_ra;
        logic [DW-1:0] m_hold, tmp;
        logic          e_we, e_re, a_p, b_p;
        logic [1:0]    e_ack, e_val;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic [MW-1:0] e_mask;

        for (int i = 0; i < 16; i++) dram[i] = rand_line();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int q = 0; q < 2; q++) begin
            on[q] = 1'b0; ph[q] = 0; gap[q] = 0;
            ra[q] = '0; rd[q] = '0; rm[q] = '0; rw[q] = 1'b0; rr[q] = 1'b0;
        end
        m_free = 0; m_from = 0; m_own = 0; m_last = 1; m_rd = 1'b0; d_lat = 0;
        m_ra = '0; m_hold = '0;
        e_addr = '0; e_din = '0; e_mask = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int q = 0; q < 2; q++) begin
                if (ph[q] == 1) ph[q] = 2;
                else if (ph[q] == 2) begin
                    on[q] = 1'b0; ph[q] = 0; gap[q] = $urandom_range(0, 3);
                end else if (!on[q]) begin
                    if (gap[q] > 0) gap[q]--;
                    else if ($urandom_range(0, 1) == 1) begin
                        on[q] = 1'b1;
                        kind  = $urandom_range(0, 2);
                        rw[q] = (kind != 1);
                        rr[q] = (kind != 0);
                        ra[q] = AW'($urandom_range(0, 15));
                        rd[q] = rand_line();
                        rm[q] = MW'($urandom());
                    end
                end
            end
            a_we = on[0] & rw[0]; a_re = on[0] & rr[0];
            a_addr = ra[0]; a_din = rd[0]; a_mask = rm[0];
            b_we = on[1] & rw[1]; b_re = on[1] & rr[1];
            b_addr = ra[1]; b_din = rd[1]; b_mask = rm[1];
            if (m_rd) begin
                mem_ready = (c < m_from) || (c >= m_from + d_lat);
                mem_dout  = (c >= m_from + d_lat) ? dram[m_ra[3:0]] : rand_line();
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
                mem_dout  = rand_line();
            end
            e_we = 1'b0; e_re = 1'b0; e_ack = 2'b00; e_val = 2'b00;
            a_p = a_we | a_re;
            b_p = b_we | b_re;
            if (m_rd) begin
                if (c >= m_from && mem_ready) begin
                    e_val[m_own] = 1'b1;
                    m_hold = dram[m_ra[3:0]];
                    m_rd   = 1'b0;
                    m_free = c + 1;
                end
            end else if (c >= m_free && mem_ready && (a_p || b_p)) begin
                s = (a_p && b_p) ? 1 - m_last : (b_p ? 1 : 0);
                m_last   = s;
                e_ack[s] = 1'b1;
                e_addr   = ra[s]; e_din = rd[s]; e_mask = rm[s];
                if (rr[s]) begin
                    e_re   = 1'b1;
                    m_rd   = 1'b1;
                    m_from = c + 3;
                    m_own  = s;
                    m_ra   = ra[s];
                    d_lat  = $urandom_range(0, 6);
                end else begin
                    e_we = 1'b1;
                    tmp  = dram[ra[s][3:0]];
                    for (int b = 0; b < MW; b++)
                        if (rm[s][b]) tmp[8*b +: 8] = rd[s][8*b +: 8];
                    dram[ra[s][3:0]] = tmp;
                    m_free = c + 3;
                end
            end
            tick();
            total++;
            if ({mem_we, mem_re, a_ack, b_ack, a_valid, b_valid}
                !== {e_we, e_re, e_ack[0], e_ack[1], e_val[0], e_val[1]}) begin
                bad++;
                $display("FAIL rand_ctl c=%0d: we/re/aack/back/aval/bval=%b want %b", c,
                    {mem_we, mem_re, a_ack, b_ack, a_valid, b_valid},
                    {e_we, e_re, e_ack[0], e_ack[1], e_val[0], e_val[1]});
            end
            total++;
            if (rd_data !== m_hold) begin
                bad++;
                $display("FAIL rand_rd_data c=%0d: %h want %h", c, rd_data, m_hold);
            end
            if (e_we || e_re) begin
                total++;
                if (mem_addr !== e_addr || mem_din !== e_din || mem_mask !== e_mask) begin
                    bad++;
                    $display("FAIL rand_payload c=%0d: addr=%h mask=%h want %h %h",
                        c, mem_addr, mem_mask, e_addr, e_mask);
                end
            end
            for (int q = 0; q < 2; q++)
                if (e_ack[q]) ph[q] = 1;
        end
        idle_inputs();
        repeat (12) tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_contention();
        test_read();
        test_blocking();
        test_reset_mid_read();
        test_random(800);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
